// File: rtl/crypto_multikey_ctrl.sv
// crypto_multikey_ctrl: register-mapped front end for a block-cipher core.
// Holds write-only key slots, an input/output data block, lockable registers,
// a start/busy/done FSM with a timeout, and a level done interrupt.
// Optional build macro: CRYPTO_ZEROIZE_EN (CTRL bit 3 zeroizes keys and DATA_OUT,
// and a timeout also zeroizes the keys).
module crypto_multikey_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int NUM_KEY_SLOTS  = 3,
   parameter int KEY_WORDS      = 6,
   parameter int BLOCK_WORDS    = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [7:0]                reglk_ctrl_i,
   input  logic [ADDR_WIDTH-1:0]     bus_addr_i,
   input  logic                      bus_write_i,
   input  logic                      bus_valid_i,
   input  logic [31:0]               bus_wdata_i,
   output logic [31:0]               bus_rdata_o,
   output logic                      bus_ready_o,
   output logic                      bus_error_o,
   output logic                      core_start_o,
   output logic [32*KEY_WORDS-1:0]   core_key_o,
   output logic [32*BLOCK_WORDS-1:0] core_block_o,
   input  logic [32*BLOCK_WORDS-1:0] core_block_i,
   input  logic                      core_valid_i,
   output logic                      irq_o
);

   localparam int KEY_WIDTH   = 32 * KEY_WORDS;
   localparam int BLOCK_WIDTH = 32 * BLOCK_WORDS;
   localparam int CNT_W       = $clog2(TIMEOUT_CYCLES);

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       IDX_CTRL    = 8'd0;
   localparam logic [7:0]       IDX_STATUS  = 8'd1;
   localparam logic [7:0]       IDX_KEYSEL  = 8'd2;
   localparam logic [7:0]       IDX_DIN     = 8'd8;
   localparam logic [7:0]       IDX_DIN_END = 8'(8 + BLOCK_WORDS);
   localparam logic [7:0]       IDX_DOUT    = 8'd16;
   localparam logic [7:0]       IDX_DOUT_END = 8'(16 + BLOCK_WORDS);
   localparam logic [7:0]       IDX_KEY     = 8'd32;
   localparam logic [7:0]       IDX_KEY_END = 8'(32 + 8 * NUM_KEY_SLOTS);
   localparam logic [3:0]       NUM_SLOTS_L = 4'(NUM_KEY_SLOTS);
   localparam logic [3:0]       KEY_WORDS_L = 4'(KEY_WORDS);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             irq_en_q, irq_en_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             err_q, err_d;
   logic             core_start_q, core_start_d;
   logic [2:0]       key_sel_q, key_sel_d;
   logic [31:0]      data_in_q  [BLOCK_WORDS];
   logic [31:0]      data_in_d  [BLOCK_WORDS];
   logic [31:0]      data_out_q [BLOCK_WORDS];
   logic [31:0]      data_out_d [BLOCK_WORDS];
   logic [31:0]      keys_q [NUM_KEY_SLOTS][KEY_WORDS];
   logic [31:0]      keys_d [NUM_KEY_SLOTS][KEY_WORDS];

   logic [7:0] idx;
   logic [7:0] key_off;
   logic [2:0] key_slot;
   logic [2:0] key_word;
   logic       key_hit;
   logic       wr_en;
   logic       busy;
   logic       start_req;
   logic       abort_req;
   logic       unused_bits;
`ifdef CRYPTO_ZEROIZE_EN
   logic       zeroize_req;
`endif

   assign idx         = bus_addr_i[9:2];
   assign key_off     = idx - IDX_KEY;
   assign key_slot    = key_off[5:3];
   assign key_word    = key_off[2:0];
   assign key_hit     = (idx >= IDX_KEY) && (idx < IDX_KEY_END) && ({1'b0, key_word} < KEY_WORDS_L);
   assign wr_en       = bus_valid_i & bus_write_i;
   assign busy        = (state_q == BUSY);
   assign bus_ready_o = 1'b1;
   assign core_start_o = core_start_q;
   assign irq_o       = done_q & irq_en_q;
   assign unused_bits = ^{bus_addr_i[ADDR_WIDTH-1:10], bus_addr_i[1:0], key_off[7:6],
                          reglk_ctrl_i[7], bus_wdata_i[3]};

   // Register writes, lock/busy rejection, and the IDLE/BUSY sequencer
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      irq_en_d     = irq_en_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      err_d        = err_q;
      key_sel_d    = key_sel_q;
      core_start_d = 1'b0;
      data_in_d    = data_in_q;
      data_out_d   = data_out_q;
      keys_d       = keys_q;
      bus_error_o  = 1'b0;
      start_req    = 1'b0;
      abort_req    = 1'b0;
`ifdef CRYPTO_ZEROIZE_EN
      zeroize_req  = 1'b0;
`endif

      if (wr_en) begin
         if (idx == IDX_CTRL) begin
            if (reglk_ctrl_i[1]) begin
               bus_error_o = 1'b1;
            end else begin
               irq_en_d  = bus_wdata_i[2];
               abort_req = bus_wdata_i[1];
               if (bus_wdata_i[0]) begin
                  if (busy || ({1'b0, key_sel_q} >= NUM_SLOTS_L)) begin
                     err_d       = 1'b1;
                     bus_error_o = 1'b1;
                  end else begin
                     start_req = 1'b1;
                  end
               end
`ifdef CRYPTO_ZEROIZE_EN
               if (bus_wdata_i[3]) begin
                  if (busy) begin
                     err_d       = 1'b1;
                     bus_error_o = 1'b1;
                  end else if (reglk_ctrl_i[5]) begin
                     bus_error_o = 1'b1;
                  end else begin
                     zeroize_req = 1'b1;
                  end
               end
`endif
            end
         end else if (idx == IDX_STATUS) begin
            if (reglk_ctrl_i[6]) begin
               bus_error_o = 1'b1;
            end else begin
               done_d    = done_q    & ~bus_wdata_i[0];
               timeout_d = timeout_q & ~bus_wdata_i[1];
               err_d     = err_q     & ~bus_wdata_i[2];
            end
         end else if (idx == IDX_KEYSEL) begin
            if (reglk_ctrl_i[1]) begin
               bus_error_o = 1'b1;
            end else if (busy) begin
               err_d       = 1'b1;
               bus_error_o = 1'b1;
            end else begin
               key_sel_d = bus_wdata_i[2:0];
            end
         end else if ((idx >= IDX_DIN) && (idx < IDX_DIN_END)) begin
            if (reglk_ctrl_i[3]) begin
               bus_error_o = 1'b1;
            end else if (busy) begin
               err_d       = 1'b1;
               bus_error_o = 1'b1;
            end else begin
               for (int w = 0; w < BLOCK_WORDS; w++) begin
                  if (idx == 8'(8 + w)) data_in_d[w] = bus_wdata_i;
               end
            end
         end else if (key_hit) begin
            if (reglk_ctrl_i[5]) begin
               bus_error_o = 1'b1;
            end else if (busy) begin
               err_d       = 1'b1;
               bus_error_o = 1'b1;
            end else begin
               for (int s = 0; s < NUM_KEY_SLOTS; s++) begin
                  for (int w = 0; w < KEY_WORDS; w++) begin
                     if ((key_slot == 3'(s)) && (key_word == 3'(w))) keys_d[s][w] = bus_wdata_i;
                  end
               end
            end
         end
      end

      // Hardware flag sets come after the W1C handling so a coincident set wins
      case (state_q)
         IDLE: begin
            if (start_req) begin
               state_d      = BUSY;
               core_start_d = 1'b1;
               done_d       = 1'b0;
               timeout_d    = 1'b0;
               cnt_d        = '0;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (core_valid_i) begin
               for (int w = 0; w < BLOCK_WORDS; w++) begin
                  data_out_d[w] = core_block_i[BLOCK_WIDTH-1-32*w -: 32];
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (abort_req) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
`ifdef CRYPTO_ZEROIZE_EN
               for (int s = 0; s < NUM_KEY_SLOTS; s++) begin
                  for (int w = 0; w < KEY_WORDS; w++) keys_d[s][w] = '0;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef CRYPTO_ZEROIZE_EN
      if (zeroize_req) begin
         for (int s = 0; s < NUM_KEY_SLOTS; s++) begin
            for (int w = 0; w < KEY_WORDS; w++) keys_d[s][w] = '0;
         end
         for (int w = 0; w < BLOCK_WORDS; w++) data_out_d[w] = '0;
      end
`endif
   end

   // Side-effect-free read mux; locked or write-only locations read as zero
   always_comb begin
      bus_rdata_o = '0;
      if (idx == IDX_CTRL) begin
         if (!reglk_ctrl_i[0]) bus_rdata_o = {29'd0, irq_en_q, 1'b0, busy};
      end else if (idx == IDX_STATUS) begin
         if (!reglk_ctrl_i[0]) bus_rdata_o = {29'd0, err_q, timeout_q, done_q};
      end else if (idx == IDX_KEYSEL) begin
         bus_rdata_o = {29'd0, key_sel_q};
      end else if ((idx >= IDX_DIN) && (idx < IDX_DIN_END)) begin
         if (!reglk_ctrl_i[2]) begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
               if (idx == 8'(8 + w)) bus_rdata_o = data_in_q[w];
            end
         end
      end else if ((idx >= IDX_DOUT) && (idx < IDX_DOUT_END)) begin
         if (!reglk_ctrl_i[4]) begin
            for (int w = 0; w < BLOCK_WORDS; w++) begin
               if (idx == 8'(16 + w)) bus_rdata_o = data_out_q[w];
            end
         end
      end
   end

   // Present the selected key and input block to the core, word 0 in the MSBs
   always_comb begin
      core_key_o   = '0;
      core_block_o = '0;
      for (int s = 0; s < NUM_KEY_SLOTS; s++) begin
         if (key_sel_q == 3'(s)) begin
            for (int w = 0; w < KEY_WORDS; w++) core_key_o[KEY_WIDTH-1-32*w -: 32] = keys_q[s][w];
         end
      end
      for (int w = 0; w < BLOCK_WORDS; w++) core_block_o[BLOCK_WIDTH-1-32*w -: 32] = data_in_q[w];
   end

   // State, flag, counter and storage registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         err_q        <= 1'b0;
         core_start_q <= 1'b0;
         key_sel_q    <= '0;
         for (int w = 0; w < BLOCK_WORDS; w++) begin
            data_in_q[w]  <= '0;
            data_out_q[w] <= '0;
         end
         for (int s = 0; s < NUM_KEY_SLOTS; s++) begin
            for (int w = 0; w < KEY_WORDS; w++) keys_q[s][w] <= '0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         err_q        <= err_d;
         core_start_q <= core_start_d;
         key_sel_q    <= key_sel_d;
         data_in_q    <= data_in_d;
         data_out_q   <= data_out_d;
         keys_q       <= keys_d;
      end
   end

endmodule
